// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the multi-channel FIR controller.
// Widths here follow the default parameters of fir_ctrl_mc; override both together.
package fir_ctrl_pkg;

   localparam int DEF_MAX_TAPS    = 64;
   localparam int DEF_MAX_SAMPLES = 1024;
   localparam int DEF_N_CH        = 2;
   localparam int CFG_TAP_W       = $clog2(DEF_MAX_TAPS + 1);
   localparam int CFG_SMP_W       = $clog2(DEF_MAX_SAMPLES + 1);
   localparam int CFG_CH_W        = (DEF_N_CH > 1) ? $clog2(DEF_N_CH) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      LOAD  = 3'd2,
      MAC   = 3'd3,
      STORE = 3'd4,
      NEXT  = 3'd5,
      FIN   = 3'd6
   } state_t;

   typedef struct packed {
      logic [CFG_TAP_W-1:0] taps;
      logic [CFG_SMP_W-1:0] samples;
      logic [DEF_N_CH-1:0]  ch_mask;
   } cfg_t;

   function automatic logic cfg_legal(cfg_t c, int max_taps, int max_samples);
      return (c.taps != '0) && (int'(c.taps) <= max_taps) &&
             (c.samples != '0) && (int'(c.samples) <= max_samples) &&
             (c.ch_mask != '0);
   endfunction

   function automatic logic [CFG_CH_W-1:0] first_set(logic [DEF_N_CH-1:0] mask);
      logic [CFG_CH_W-1:0] r;
      r = '0;
      for (int i = DEF_N_CH - 1; i >= 0; i--) begin
         if (mask[i]) r = CFG_CH_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_ctrl_ch_sel.sv
// Next enabled channel above ch_idx; last_ch flags that no higher mask bit is set.
module fir_ctrl_ch_sel #(
   parameter int N_CH = 2,
   parameter int CH_W = 1
) (
   input  logic [N_CH-1:0] mask,
   input  logic [CH_W-1:0] ch_idx,
   output logic [CH_W-1:0] next_ch,
   output logic            last_ch
);

   // Scan downward so the lowest qualifying bit is the one left standing.
   always_comb begin
      next_ch = '0;
      last_ch = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(ch_idx))) begin
            next_ch = CH_W'(i);
            last_ch = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fir_ctrl_mc.sv
// Multi-channel FIR sequencing controller: taps x channels x samples per run.
// Optional FIR_CTRL_PERF_EN adds an output stall-cycle counter on stall_cnt.
//
// state | meaning
// IDLE  | waiting for start, config checked here
// INIT  | load coefficients, clear shift regs and accumulator
// LOAD  | push one sample into channel ch_idx
// MAC   | accumulate taps 0..T-1
// STORE | hold out_valid until out_ready
// NEXT  | clear accumulator, step channel and/or sample
// FIN   | done pulse, back to IDLE
module fir_ctrl_mc
   import fir_ctrl_pkg::*;
#(
   parameter int MAX_TAPS    = DEF_MAX_TAPS,
   parameter int MAX_SAMPLES = DEF_MAX_SAMPLES,
   parameter int N_CH        = DEF_N_CH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              abort,
   input  logic [$clog2(MAX_TAPS+1)-1:0]     cfg_taps,
   input  logic [$clog2(MAX_SAMPLES+1)-1:0]  cfg_samples,
   input  logic [N_CH-1:0]                   cfg_ch_mask,
   output logic                              busy,
   output logic                              done,
   output logic                              aborted,
   output logic                              cfg_err,
   output logic                              mux_sel,
   output logic                              coef_load,
   output logic                              shift_clr,
   output logic                              shift_en,
   output logic [$clog2(MAX_TAPS+1)-1:0]     tap_idx,
   output logic [$clog2(MAX_SAMPLES+1)-1:0]  smp_idx,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_idx,
   output logic                              acc_clr,
   output logic                              acc_en,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              sample_adv,
   output logic [15:0]                       stall_cnt
);

   localparam int TAP_W = $clog2(MAX_TAPS + 1);
   localparam int SMP_W = $clog2(MAX_SAMPLES + 1);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_t          state;
   cfg_t            cfg;
   cfg_t            cfg_in;
   logic [CH_W-1:0] next_ch;
   logic            last_ch;
   logic            tap_last;
   logic            smp_last;

   assign cfg_in   = '{taps: cfg_taps, samples: cfg_samples, ch_mask: cfg_ch_mask};
   assign tap_last = (tap_idx == (cfg.taps - TAP_W'(1)));
   assign smp_last = (smp_idx == (cfg.samples - SMP_W'(1)));
   assign mux_sel  = busy;

   fir_ctrl_ch_sel #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_ch_sel (
      .mask    (cfg.ch_mask),
      .ch_idx  (ch_idx),
      .next_ch (next_ch),
      .last_ch (last_ch)
   );

   // Outputs are registered alongside the state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cfg        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         cfg_err    <= 1'b0;
         coef_load  <= 1'b0;
         shift_clr  <= 1'b0;
         shift_en   <= 1'b0;
         tap_idx    <= '0;
         smp_idx    <= '0;
         ch_idx     <= '0;
         acc_clr    <= 1'b0;
         acc_en     <= 1'b0;
         out_valid  <= 1'b0;
         sample_adv <= 1'b0;
      end else begin
         done       <= 1'b0;
         aborted    <= 1'b0;
         cfg_err    <= 1'b0;
         coef_load  <= 1'b0;
         shift_clr  <= 1'b0;
         shift_en   <= 1'b0;
         acc_clr    <= 1'b0;
         acc_en     <= 1'b0;
         sample_adv <= 1'b0;
         if (abort && busy) begin
            // Abort wins over a same-cycle handshake; that result is dropped.
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            aborted   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (cfg_legal(cfg_in, MAX_TAPS, MAX_SAMPLES)) begin
                        cfg       <= cfg_in;
                        state     <= INIT;
                        busy      <= 1'b1;
                        coef_load <= 1'b1;
                        shift_clr <= 1'b1;
                        acc_clr   <= 1'b1;
                        tap_idx   <= '0;
                        smp_idx   <= '0;
                        ch_idx    <= first_set(cfg_ch_mask);
                     end else begin
                        cfg_err <= 1'b1;
                     end
                  end
               end
               INIT: begin
                  state    <= LOAD;
                  shift_en <= 1'b1;
                  tap_idx  <= '0;
               end
               LOAD: begin
                  state   <= MAC;
                  acc_en  <= 1'b1;
                  tap_idx <= '0;
               end
               MAC: begin
                  if (tap_last) begin
                     state     <= STORE;
                     out_valid <= 1'b1;
                  end else begin
                     acc_en  <= 1'b1;
                     tap_idx <= tap_idx + TAP_W'(1);
                  end
               end
               STORE: begin
                  if (out_ready) begin
                     state      <= NEXT;
                     out_valid  <= 1'b0;
                     acc_clr    <= 1'b1;
                     sample_adv <= last_ch;
                  end
               end
               NEXT: begin
                  if (!last_ch) begin
                     ch_idx   <= next_ch;
                     state    <= LOAD;
                     shift_en <= 1'b1;
                     tap_idx  <= '0;
                  end else begin
                     ch_idx <= first_set(cfg.ch_mask);
                     if (smp_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        smp_idx  <= smp_idx + SMP_W'(1);
                        state    <= LOAD;
                        shift_en <= 1'b1;
                        tap_idx  <= '0;
                     end
                  end
               end
               FIN: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef FIR_CTRL_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (state == INIT) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
